// File: rtl/spi_shift_engine_if.sv
// Bus bundle between an SPI shift engine and its controller.
// The master side is the engine itself; the slave side drives requests and frame data.
interface spi_shift_engine_if #(
    parameter int D_WIDTH = 8
);
    logic               enable;
    logic               cpol;
    logic               cpha;
    logic               cont;
    logic [7:0]         clk_div;
    logic [D_WIDTH-1:0] tx_data;
    logic               miso;
    logic               sclk;
    logic               ss_n;
    logic               mosi;
    logic               busy;
    logic [D_WIDTH-1:0] rx_data;
    logic               done;

    modport master (
        input  enable, cpol, cpha, cont, clk_div, tx_data, miso,
        output sclk, ss_n, mosi, busy, rx_data, done
    );

    modport slave (
        output enable, cpol, cpha, cont, clk_div, tx_data, miso,
        input  sclk, ss_n, mosi, busy, rx_data, done
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one frame of D_WIDTH bits, MSB first, all four CPOL/CPHA modes,
// optional continuous mode keeping ss_n low across back-to-back frames.
module spi_shift_engine #(
    parameter int D_WIDTH = 8
) (
    input logic                clk,
    input logic                reset_n,
    spi_shift_engine_if.master bus
);
    localparam int             EW           = $clog2(2 * D_WIDTH + 1);
    localparam logic [EW-1:0]  LAST_EDGE    = EW'(2 * D_WIDTH);
    localparam logic [EW-1:0]  FINAL_LAUNCH = EW'(2 * D_WIDTH - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state, state_next;
    logic [7:0]         div_l;
    logic [7:0]         hp_cnt;
    logic               cpha_l;
    logic [EW-1:0]      edge_cnt;
    logic [D_WIDTH-1:0] tx_sh;
    logic [D_WIDTH-1:0] rx_sh;
    logic               hp_hit;
    logic               edge_tick;
    logic               frame_end;
    logic               start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // After the last sclk edge one more half-period runs before the frame closes.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        edge_tick  = 1'b0;
        frame_end  = 1'b0;
        hp_hit     = (hp_cnt == div_l);
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    start      = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (hp_hit) begin
                    if (edge_cnt == LAST_EDGE) begin
                        frame_end = 1'b1;
                        if (bus.cont && bus.enable) start = 1'b1;
                        else                        state_next = IDLE;
                    end else begin
                        edge_tick = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_sh always holds the next bit to launch in its MSB; with cpha=0 the MSB is
    // already on mosi at frame start, so the register is pre-shifted by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_l    <= '0;
            cpha_l   <= 1'b0;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bus.sclk <= 1'b0;
            bus.ss_n <= 1'b1;
            bus.mosi <= 1'b0;
            bus.busy <= 1'b0;
        end else if (start) begin
            div_l    <= bus.clk_div;
            cpha_l   <= bus.cpha;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            tx_sh    <= bus.cpha ? bus.tx_data : {bus.tx_data[D_WIDTH-2:0], 1'b0};
            rx_sh    <= '0;
            bus.mosi <= bus.tx_data[D_WIDTH-1];
            bus.sclk <= bus.cpol;
            bus.ss_n <= 1'b0;
            bus.busy <= 1'b1;
        end else if (state == IDLE || frame_end) begin
            hp_cnt   <= '0;
            bus.sclk <= bus.cpol;
            bus.ss_n <= 1'b1;
            bus.busy <= 1'b0;
        end else begin
            hp_cnt <= hp_hit ? 8'd0 : hp_cnt + 8'd1;
            if (edge_tick) begin
                bus.sclk <= ~bus.sclk;
                edge_cnt <= edge_cnt + EW'(1);
                // edge_cnt[0]==0 marks an odd (leading) edge
                if (edge_cnt[0] == cpha_l) begin
                    rx_sh <= {rx_sh[D_WIDTH-2:0], bus.miso};
                end else if (cpha_l || edge_cnt != FINAL_LAUNCH) begin
                    bus.mosi <= tx_sh[D_WIDTH-1];
                    tx_sh    <= {tx_sh[D_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rx_data <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= frame_end;
            if (frame_end) bus.rx_data <= rx_sh;
        end
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed mode/continuous/reset scenarios plus
// randomized frames against a protocol-level slave and monitor.
module tb_spi_shift_engine;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_shift_engine_if #(.D_WIDTH(D)) bus ();
    spi_shift_engine #(.D_WIDTH(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    bit           loop_mode  = 1'b1;
    logic         sl_bit     = 1'b0;
    logic [D-1:0] sl_sh      = '0;
    logic [D-1:0] slave_word = '0;
    logic         frame_cpha = 1'b0;
    int           e_cnt      = 0;
    logic         ss_prev    = 1'b1;
    logic         sclk_prev  = 1'b0;
    logic [D-1:0] mon_bits   = '0;
    logic [D-1:0] mon_q[$];

    assign bus.miso = loop_mode ? bus.mosi : sl_bit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI slave + mosi monitor: counts sclk transitions while selected, captures mosi on
    // sampling edges and launches the slave's next bit on the opposite edges.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_cnt     = 0;
            ss_prev   = 1'b1;
            sclk_prev = 1'b0;
            mon_bits  = '0;
        end else begin
            if (ss_prev && !bus.ss_n) begin
                e_cnt    = 0;
                mon_bits = '0;
                sl_sh    = slave_word;
                sl_bit   = slave_word[D-1];
                if (!frame_cpha) sl_sh = sl_sh << 1;
            end else if (!ss_prev && !bus.ss_n && bus.sclk != sclk_prev) begin
                e_cnt++;
                if ((e_cnt % 2 == 1) != frame_cpha) begin
                    mon_bits = {mon_bits[D-2:0], bus.mosi};
                end else begin
                    sl_bit = sl_sh[D-1];
                    sl_sh  = sl_sh << 1;
                end
                if (e_cnt == 2 * D) begin
                    mon_q.push_back(mon_bits);
                    e_cnt = 0;
                end
            end
            ss_prev   = bus.ss_n;
            sclk_prev = bus.sclk;
        end
    end

    task automatic run_frame(input string tag, input logic [D-1:0] tx, input logic cp,
                             input logic ch, input logic [7:0] dv, input bit lp,
                             input logic [D-1:0] sw, input bit perturb);
        int           busy_cnt;
        int           ss_hi;
        int           done_cnt;
        int           guard;
        logic [D-1:0] exp_rx;
        logic [D-1:0] first_word;
        @(negedge clk);
        loop_mode   = lp;
        slave_word  = sw;
        frame_cpha  = ch;
        bus.cont    = 1'b0;
        bus.cpol    = cp;
        bus.cpha    = ch;
        bus.clk_div = dv;
        bus.tx_data = tx;
        mon_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk({tag, " sclk_idle"}, 32'(bus.sclk), 32'(cp));
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        busy_cnt = 0; ss_hi = 0; done_cnt = 0; guard = 0;
        while (bus.busy && guard < 3000) begin
            busy_cnt++;
            guard++;
            if (bus.ss_n) ss_hi++;
            if (bus.done) done_cnt++;
            if (perturb && busy_cnt == 3) begin
                bus.tx_data = ~tx;
                bus.cpol    = ~cp;
                bus.cpha    = ~ch;
                bus.clk_div = dv + 8'd1;
            end
            @(negedge clk);
        end
        exp_rx = lp ? tx : sw;
        chk({tag, " busy_len"}, 32'(busy_cnt), 32'((2 * D + 1) * (int'(dv) + 1)));
        chk({tag, " ss_n_low"}, 32'(ss_hi), 32'd0);
        chk({tag, " done_early"}, 32'(done_cnt), 32'd0);
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd1);
        chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
        chk({tag, " edges"}, 32'(mon_q.size()), 32'd1);
        first_word = (mon_q.size() > 0) ? mon_q[0] : ~tx;
        chk({tag, " mosi_bits"}, 32'(first_word), 32'(tx));
        @(negedge clk);
        chk({tag, " done_clear"}, 32'(bus.done), 32'd0);
        chk({tag, " rx_hold"}, 32'(bus.rx_data), 32'(exp_rx));
    endtask

    task automatic cont_test();
        int           busy_cnt = 0;
        int           ss_hi = 0;
        int           dones = 0;
        logic [D-1:0] w;
        @(negedge clk);
        loop_mode   = 1'b1;
        frame_cpha  = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = 8'd0;
        bus.cont    = 1'b1;
        bus.tx_data = 8'h12;
        mon_q.delete();
        @(negedge clk);
        bus.enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (bus.ss_n) ss_hi++;
            end
            if (c == 3) bus.tx_data = 8'h34;
            if (bus.done) begin
                chk("cont rx_frame", 32'(bus.rx_data), (dones == 0) ? 32'h12 : 32'h34);
                dones++;
                bus.enable = 1'b0;
            end
            if (dones >= 2) break;
        end
        chk("cont done_count", 32'(dones), 32'd2);
        chk("cont busy_len", 32'(busy_cnt), 32'(2 * (2 * D + 1)));
        chk("cont ss_n_low", 32'(ss_hi), 32'd0);
        chk("cont frames_seen", 32'(mon_q.size()), 32'd2);
        w = (mon_q.size() > 1) ? mon_q[1] : 8'h00;
        chk("cont mosi_frame2", 32'(w), 32'h34);
        bus.cont = 1'b0;
        @(negedge clk);
        chk("cont idle_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic gap_test(input logic [D-1:0] tx);
        int g = 0;
        int ss_hi = 0;
        @(negedge clk);
        loop_mode   = 1'b1;
        frame_cpha  = 1'b0;
        bus.cont    = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = 8'd0;
        bus.tx_data = tx;
        bus.enable  = 1'b1;
        @(negedge clk);
        while (!bus.busy && g < 50) begin @(negedge clk); g++; end
        while (bus.busy && g < 200) begin @(negedge clk); g++; end
        chk("gap rx_first", 32'(bus.rx_data), 32'(tx));
        while (bus.ss_n && g < 220) begin ss_hi++; @(negedge clk); g++; end
        chk("gap ss_n_high_cycles", 32'(ss_hi), 32'd1);
        bus.enable = 1'b0;
        while (bus.busy && g < 400) begin @(negedge clk); g++; end
        chk("gap rx_second", 32'(bus.rx_data), 32'(tx));
        chk("gap done_second", 32'(bus.done), 32'd1);
    endtask

    task automatic reset_mid_test(input logic [D-1:0] tx);
        int g = 0;
        int dn = 0;
        @(negedge clk);
        loop_mode   = 1'b1;
        frame_cpha  = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = 8'd1;
        bus.tx_data = tx;
        bus.enable  = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        while (e_cnt != 5 && g < 200) begin @(negedge clk); g++; end
        chk("rst reached_edge5", 32'(e_cnt), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst async sclk", 32'(bus.sclk), 32'd0);
        chk("rst async ss_n", 32'(bus.ss_n), 32'd1);
        chk("rst async mosi", 32'(bus.mosi), 32'd0);
        chk("rst async busy", 32'(bus.busy), 32'd0);
        chk("rst async done", 32'(bus.done), 32'd0);
        chk("rst async rx_data", 32'(bus.rx_data), 32'd0);
        repeat (2) begin @(negedge clk); if (bus.done) dn++; end
        reset_n = 1'b1;
        repeat (4) begin @(negedge clk); if (bus.done) dn++; end
        chk("rst no_done", 32'(dn), 32'd0);
        chk("rst stays_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [D-1:0] r_tx;
        logic [D-1:0] r_sw;
        logic         r_cp;
        logic         r_ch;
        logic [7:0]   r_dv;
        bit           r_lp;
        reset_n     = 1'b0;
        bus.enable  = 1'b0;
        bus.cont    = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = 8'd0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset sclk", 32'(bus.sclk), 32'd0);
        chk("reset ss_n", 32'(bus.ss_n), 32'd1);
        chk("reset mosi", 32'(bus.mosi), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset rx_data", 32'(bus.rx_data), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_start_without_enable", 32'(bus.busy), 32'd0);

        run_frame("mode0_a5", 8'hA5, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 1'b0);
        r_tx = D'($urandom);
        run_frame("mode3_3c", r_tx, 1'b1, 1'b1, 8'd3, 1'b0, 8'h3C, 1'b0);
        cont_test();
        gap_test(D'($urandom_range(1, 255)));
        reset_mid_test(D'($urandom_range(1, 255)));
        r_tx = D'($urandom);
        run_frame("after_reset", r_tx, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) begin
            r_tx = D'($urandom);
            r_sw = D'($urandom);
            r_cp = 1'($urandom);
            r_ch = 1'($urandom);
            r_dv = 8'($urandom_range(0, 4));
            r_lp = 1'($urandom);
            run_frame($sformatf("rnd%0d", i), r_tx, r_cp, r_ch, r_dv, r_lp, r_sw, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
